// File: rtl/inst_decode_pkg.sv
// Shared constants and types for the instruction decode pipeline.
package inst_decode_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    function automatic bit xlen_legal(input int x);
        return (x == 32) || (x == 64);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational decode of one 32-bit RISC-V word into fields, format and immediate.
module inst_field_decode
    import inst_decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instruction,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            is_word
);

    // Raw fields are positional and reported regardless of legality
    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign func3  = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign func7  = instruction[31:25];

    // Opcode -> format, W-op flag and sign-extended immediate
    always_comb begin
        fmt     = FMT_ILL;
        is_word = 1'b0;
        imm     = '0;
        case (instruction[6:0])
            OP_OP: fmt = FMT_R;
            OP_OP_32: begin
                // W-ops only exist on a 64-bit datapath
                if (XLEN == 64) begin
                    fmt     = FMT_R;
                    is_word = 1'b1;
                end
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instruction[31:20]));
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_I;
                    is_word = 1'b1;
                    imm     = XLEN'($signed(instruction[31:20]));
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                     instruction[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instruction[31:12], 12'h000}));
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                     instruction[30:21], 1'b0}));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_decode_pipe.sv
// Decode stage with a small output FIFO holding decoded entries.
module inst_decode_pipe
    import inst_decode_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            is_word,
    output logic            illegal,
    output logic [15:0]     illegal_count
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("inst_decode_pipe: XLEN must be 32 or 64");
    end
    if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
        $error("inst_decode_pipe: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            is_word;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic            ready_en;
    logic            push;
    logic            pop;

    inst_field_decode #(.XLEN(XLEN)) u_dec (
        .instruction (instruction),
        .opcode      (dec.opcode),
        .rd          (dec.rd),
        .func3       (dec.func3),
        .rs1         (dec.rs1),
        .rs2         (dec.rs2),
        .func7       (dec.func7),
        .imm         (dec.imm),
        .fmt         (dec.fmt),
        .is_word     (dec.is_word)
    );

    // ready_en holds in_ready low during reset and until the first edge after it
    assign in_ready  = ready_en && (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rptr];

    // Ready enable: cleared by reset, set on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Storage is not reset; out_valid gating hides stale contents
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating count of accepted illegal words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_count <= '0;
        else if (push && dec.fmt == FMT_ILL && illegal_count != 16'hFFFF)
            illegal_count <= illegal_count + 16'd1;
    end

    // Head presentation, forced to zero while the FIFO is empty
    always_comb begin
        opcode  = '0;
        rd      = '0;
        func3   = '0;
        rs1     = '0;
        rs2     = '0;
        func7   = '0;
        imm     = '0;
        fmt     = '0;
        is_word = 1'b0;
        illegal = 1'b0;
        if (out_valid) begin
            opcode  = head.opcode;
            rd      = head.rd;
            func3   = head.func3;
            rs1     = head.rs1;
            rs2     = head.rs2;
            func7   = head.func7;
            imm     = head.imm;
            fmt     = head.fmt;
            is_word = head.is_word;
            illegal = (head.fmt == FMT_ILL);
        end
    end

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Scoreboard bench: stimulus queues expected entries, a monitor checks the FIFO head.
module tb_inst_decode_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;

    // 64-bit instance
    logic        in_ready, out_valid, is_word, illegal;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3, fmt;
    logic [63:0] imm;
    logic [15:0] illegal_count;

    // 32-bit instance
    logic        in_ready32, out_valid32, is_word32, illegal32;
    logic [6:0]  opcode32, func7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  func3_32, fmt32;
    logic [31:0] imm32;
    logic [15:0] illegal_count32;

    typedef struct {
        logic [31:0] ins;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  fmt64;
        logic        w64;
        logic [2:0]  fmt32;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ill64  = 0;
    int   ill32  = 0;

    inst_decode_pipe #(.XLEN(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
        .imm(imm), .fmt(fmt), .is_word(is_word), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    inst_decode_pipe #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
        .opcode(opcode32), .rd(rd32), .func3(func3_32), .rs1(rs1_32), .rs2(rs2_32),
        .func7(func7_32), .imm(imm32), .fmt(fmt32), .is_word(is_word32),
        .illegal(illegal32), .illegal_count(illegal_count32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the word was accepted
    task automatic push(input logic [31:0] ins, input logic [6:0] op, input logic [4:0] rdv,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [6:0] f7, input logic [63:0] iv, input logic [2:0] f64,
                        input logic w, input logic [2:0] f32);
        exp_t e;
        int   n;
        e = '{ins, op, rdv, f3, r1, r2, f7, iv, f64, w, f32};
        in_valid    = 1'b1;
        instruction = ins;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 for %08h", ins);
        end else begin
            q.push_back(e);
            if (f64 == 3'd7) ill64++;
            if (f32 == 3'd7) ill32++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare head against scoreboard front, pop on handshake
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ei32;
        chk("valid_match32", out_valid32, out_valid);
        if (out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got opcode %0h expected no entry", opcode);
            end else begin
                e = q[0];
                ei32 = (e.fmt32 == 3'd7) ? 32'h0 : e.imm[31:0];
                chk("opcode", opcode, e.op);
                chk("rd", rd, e.rd);
                chk("func3", func3, e.f3);
                chk("rs1", rs1, e.rs1);
                chk("rs2", rs2, e.rs2);
                chk("func7", func7, e.f7);
                chk("imm", imm, e.imm);
                chk("fmt", fmt, e.fmt64);
                chk("is_word", is_word, e.w64);
                chk("illegal", illegal, e.fmt64 == 3'd7);
                chk("rd32", rd32, e.rd);
                chk("fmt32", fmt32, e.fmt32);
                chk("imm32", imm32, ei32);
                chk("is_word32", is_word32, 1'b0);
                chk("illegal32", illegal32, e.fmt32 == 3'd7);
                if (out_ready) void'(q.pop_front());
            end
        end else begin
            chk("idle_zero", {opcode, rd, func3, rs1, rs2, func7, fmt, is_word, illegal,
                              opcode32, rd32, fmt32, illegal32} | imm | imm32, 64'h0);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = 32'h0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ill_cnt", illegal_count, 16'h0);
        chk("rst_imm", imm, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("in_ready_after_rel", in_ready, 1'b1);
        chk("in_ready32_after_rel", in_ready32, 1'b1);

        out_ready = 1'b1;
        //   ins           op     rd     f3    rs1    rs2    f7     imm                    fmt64 w fmt32
        push(32'h01330533, 7'h33, 5'd10, 3'd0, 5'd6,  5'd19, 7'h00, 64'h0,                 3'd0, 0, 3'd0);
        push(32'h01FF853B, 7'h3B, 5'd10, 3'd0, 5'd31, 5'd31, 7'h00, 64'h0,                 3'd0, 1, 3'd7);
        push(32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 3'd1);
        push(32'hFE000EE3, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0, 3'd3);
        push(32'h00A12423, 7'h23, 5'd8,  3'd2, 5'd2,  5'd10, 7'h00, 64'h8,                 3'd2, 0, 3'd2);
        push(32'h12345537, 7'h37, 5'd10, 3'd5, 5'd8,  5'd3,  7'h09, 64'h0000000012345000, 3'd4, 0, 3'd4);
        push(32'h80000037, 7'h37, 5'd0,  3'd0, 5'd0,  5'd0,  7'h40, 64'hFFFFFFFF80000000, 3'd4, 0, 3'd4);
        push(32'hFFDFF0EF, 7'h6F, 5'd1,  3'd7, 5'd31, 5'd29, 7'h7F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 0, 3'd5);
        push(32'h0015051B, 7'h1B, 5'd10, 3'd0, 5'd10, 5'd1,  7'h00, 64'h1,                 3'd1, 1, 3'd7);
        chk("ill_cnt64_a", illegal_count, 16'(ill64));
        chk("ill_cnt32_a", illegal_count32, 16'(ill32));
        drain();

        // Fill with consumer stalled, then release it
        out_ready = 1'b0;
        push(32'h00100093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd1, 7'h00, 64'h1, 3'd1, 0, 3'd1);
        push(32'h00200113, 7'h13, 5'd2, 3'd0, 5'd0, 5'd2, 7'h00, 64'h2, 3'd1, 0, 3'd1);
        chk("full_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("full_hold_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_pop", in_ready, 1'b1);
        drain();

        // Two all-zero words are illegal
        out_ready = 1'b0;
        push(32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 64'h0, 3'd7, 0, 3'd7);
        push(32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 64'h0, 3'd7, 0, 3'd7);
        chk("ill_cnt64_b", illegal_count, 16'd2);
        chk("ill_cnt32_b", illegal_count32, 16'd4);
        out_ready = 1'b1;
        drain();

        // Reset with entries in flight
        out_ready = 1'b0;
        push(32'h00100093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd1, 7'h00, 64'h1, 3'd1, 0, 3'd1);
        push(32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 64'h0, 3'd7, 0, 3'd7);
        chk("ill_cnt64_c", illegal_count, 16'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_ill_cnt", illegal_count, 16'h0);
        chk("midrst_ill_cnt32", illegal_count32, 16'h0);
        q.delete();
        ill64 = 0;
        ill32 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        push(32'h01330533, 7'h33, 5'd10, 3'd0, 5'd6, 5'd19, 7'h00, 64'h0, 3'd0, 0, 3'd0);
        drain();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
